conv_loop_sequencer: RTL and testbench

//  Loop-nest controller for the 3x3 weight-passing conv array (w0..w8 nodes, 16 lanes each).

---
 rtl/conv_loop_sequencer.sv | 167 ++++++++++++++++
 tb/tb_conv_loop_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_sequencer.sv
// Loop-nest sequencer for the 3x3 weight-passing conv array: preloads taps, then walks
// x/y inside X/Y and emits the node strobes. Optional perf counters: CONV_SEQ_PERF_EN.
module conv_loop_sequencer #(
    parameter int unsigned KW = 3,
    parameter int unsigned KH = 3,
    parameter int unsigned OW = 19,
    parameter int unsigned OH = 19,
    parameter int unsigned AW = 4,
    localparam int unsigned XW  = (KW > 1) ? $clog2(KW) : 1,
    localparam int unsigned YW  = (KH > 1) ? $clog2(KH) : 1,
    localparam int unsigned OXW = (OW > 1) ? $clog2(OW) : 1,
    localparam int unsigned OYW = (OH > 1) ? $clog2(OH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           hold,
    output logic [AW-1:0]  w_raddr,
    output logic           w_load,
    output logic [AW-1:0]  w_load_tap,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic [OXW-1:0] X,
    output logic [OYW-1:0] Y,
    output logic           shift_x,
    output logic           shift_y,
    output logic           w_return,
    output logic           acc_clr,
    output logic           out_valid,
    output logic           busy,
    output logic           finish
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]    cyc_cnt,
    output logic [31:0]    stall_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [AW-1:0]  TapLast = AW'(KW * KH - 1);
    localparam logic [XW-1:0]  XMax    = XW'(KW - 1);
    localparam logic [YW-1:0]  YMax    = YW'(KH - 1);
    localparam logic [OXW-1:0] OXMax   = OXW'(OW - 1);
    localparam logic [OYW-1:0] OYMax   = OYW'(OH - 1);

    state_e state;
    logic   issue_done;
    logic   last_cap;
    logic   cap_done;
    logic   x_end, y_end, ox_end, oy_end, win_end, run_go;

    // Last tap is captured either this cycle or during an earlier held cycle.
    assign cap_done = last_cap || (w_load && (w_load_tap == TapLast));

    assign x_end   = (x == XMax);
    assign y_end   = (y == YMax);
    assign ox_end  = (X == OXMax);
    assign oy_end  = (Y == OYMax);
    assign win_end = x_end && y_end;
    assign run_go  = (state == StRun) && !hold;

    assign shift_x   = run_go && !x_end;
    assign shift_y   = run_go && x_end && !y_end;
    assign w_return  = run_go && win_end;
    assign out_valid = run_go && win_end;
    assign acc_clr   = run_go && (x == '0) && (y == '0);
    assign busy      = (state == StLoad) || (state == StRun);
    assign finish    = (state == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            w_raddr    <= '0;
            w_load     <= 1'b0;
            w_load_tap <= '0;
            issue_done <= 1'b0;
            last_cap   <= 1'b0;
            x          <= '0;
            y          <= '0;
            X          <= '0;
            Y          <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StLoad;
                        w_raddr    <= '0;
                        w_load     <= 1'b0;
                        w_load_tap <= '0;
                        issue_done <= 1'b0;
                        last_cap   <= 1'b0;
                        x          <= '0;
                        y          <= '0;
                        X          <= '0;
                        Y          <= '0;
                    end
                end
                StLoad: begin
                    w_load <= 1'b0;
                    if (!hold) begin
                        if (!issue_done) begin
                            w_load     <= 1'b1;
                            w_load_tap <= w_raddr;
                            if (w_raddr == TapLast) begin
                                issue_done <= 1'b1;
                            end else begin
                                w_raddr <= w_raddr + 1'b1;
                            end
                        end
                        if (cap_done) begin
                            state    <= StRun;
                            w_raddr  <= '0;
                            last_cap <= 1'b0;
                        end
                    end else begin
                        last_cap <= cap_done;
                    end
                end
                StRun: begin
                    if (!hold) begin
                        x <= x_end ? '0 : x + 1'b1;
                        if (x_end) begin
                            y <= y_end ? '0 : y + 1'b1;
                        end
                        if (win_end) begin
                            X <= ox_end ? '0 : X + 1'b1;
                        end
                        if (win_end && ox_end) begin
                            Y <= oy_end ? '0 : Y + 1'b1;
                        end
                        if (win_end && ox_end && oy_end) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef CONV_SEQ_PERF_EN
    // cyc_cnt spans the accepting cycle through DONE, so one pass reads LOAD+RUN+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else if ((state == StIdle) && start) begin
            cyc_cnt   <= 32'd1;
            stall_cnt <= '0;
        end else if (state != StIdle) begin
            if (cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (busy && hold && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Directed self-checking bench for conv_loop_sequencer at default parameters.
module tb_conv_loop_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic [3:0] w_raddr, w_load_tap;
    logic       w_load;
    logic [1:0] x, y;
    logic [4:0] X, Y;
    logic       shift_x, shift_y, w_return, acc_clr, out_valid, busy, finish;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0] cyc_cnt, stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [29:0] all_out;
    logic [4:0]  strb;
    assign all_out = {w_raddr, w_load, w_load_tap, x, y, X, Y, shift_x, shift_y,
                      w_return, acc_clr, out_valid, busy, finish};
    assign strb = {shift_x, shift_y, w_return, acc_clr, out_valid};

    // Strobes {shift_x,shift_y,w_return,acc_clr,out_valid} for tap k = y*3+x of a window.
    logic [4:0] win_seq [0:8] = '{5'b10010, 5'b10000, 5'b01000, 5'b10000, 5'b10000,
                                  5'b01000, 5'b10000, 5'b10000, 5'b00101};

    always #5 clk = ~clk;

    conv_loop_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .w_raddr(w_raddr), .w_load(w_load), .w_load_tap(w_load_tap),
        .x(x), .y(y), .X(X), .Y(Y),
        .shift_x(shift_x), .shift_y(shift_y), .w_return(w_return),
        .acc_clr(acc_clr), .out_valid(out_valid), .busy(busy), .finish(finish)
`ifdef CONV_SEQ_PERF_EN
        , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        step; step;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step; #1;
            n_checks++;
            if (all_out !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h, need 0", i, all_out);
            end
        end
    endtask

    // Cycle numbers count from the cycle in which start is presented.
    task automatic test_free_run;
        int ov_cnt = 0;
        int r, k, win;
        logic [21:0] got, exp;
        step; start = 1'b1; #1;
        for (int c = 1; c <= 3262; c++) begin
            step; start = 1'b0; #1;
            if (c <= 10) begin
                n_checks++;
                if (busy !== 1'b1 || w_load !== (c >= 2) ||
                    (c >= 2 && w_load_tap !== 4'(c - 2)) || (c <= 9 && w_raddr !== 4'(c - 1))) begin
                    n_fail++;
                    $display("FAIL load_seq cyc %0d: busy=%b w_load=%b tap=%0d raddr=%0d", c, busy,
                             w_load, w_load_tap, w_raddr);
                end
            end else if (c <= 3259) begin
                r = c - 11; k = r % 9; win = r / 9;
                got = {x, y, X, Y, strb, busy, finish, w_load};
                exp = {2'(k % 3), 2'(k / 3), 5'(win % 19), 5'(win / 19), win_seq[k], 3'b100};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL run_seq cyc %0d: got %h, need %h", c, got, exp);
                end
                if (out_valid === 1'b1) ov_cnt++;
            end else begin
                n_checks++;
                if (finish !== (c == 3260) || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pass_end cyc %0d: finish=%b busy=%b", c, finish, busy);
                end
            end
        end
        n_checks++;
        if (ov_cnt !== 361) begin
            n_fail++;
            $display("FAIL out_valid_count: got %0d, need 361", ov_cnt);
        end
    endtask

    task automatic test_load_hold;
        int n_loads = 0;
        int acc_first = -1;
        step; start = 1'b1; hold = 1'b1; #1;
        for (int c = 1; c <= 20; c++) begin
            step; start = 1'b0; hold = (c >= 3 && c <= 5); #1;
            if (c == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_with_hold: busy=%b, need 1", busy);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (w_load !== 1'b1) begin
                    n_fail++;
                    $display("FAIL inflight_read: w_load=%b, need 1", w_load);
                end
            end
            if (c >= 3 && c <= 5) begin
                n_checks++;
                if (w_raddr !== 4'd2) begin
                    n_fail++;
                    $display("FAIL raddr_frozen cyc %0d: got %0d, need 2", c, w_raddr);
                end
            end
            if (w_load === 1'b1) begin
                n_checks++;
                if (w_load_tap !== 4'(n_loads)) begin
                    n_fail++;
                    $display("FAIL load_tap_order: got %0d, need %0d", w_load_tap, n_loads);
                end
                n_loads++;
            end
            if (acc_clr === 1'b1 && acc_first < 0) acc_first = c;
        end
        n_checks++;
        if (n_loads !== 9 || acc_first !== 14) begin
            n_fail++;
            $display("FAIL load_hold: loads=%0d first_acc=%0d, need 9 and 14", n_loads, acc_first);
        end
        rst = 1'b1;
        step; rst = 1'b0; #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL abort_in_run: got %h, need 0", all_out);
        end
    endtask

    task automatic test_hold;
        int fin_c = -1;
        for (int c = 0; c <= 3400 && fin_c < 0; c++) begin
            step; start = (c == 0); hold = (c >= 594 && c <= 598); #1;
            if (hold) begin
                n_checks++;
                if ({x, y, X, Y} !== {2'd1, 2'd2, 5'd7, 5'd3} || strb !== 5'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold_freeze cyc %0d: x=%0d y=%0d X=%0d Y=%0d strb=%b busy=%b", c,
                             x, y, X, Y, strb, busy);
                end
            end
            if (c == 599) begin
                n_checks++;
                if ({x, y, X, Y} !== {2'd1, 2'd2, 5'd7, 5'd3} || strb !== 5'b10000) begin
                    n_fail++;
                    $display("FAIL hold_release: x=%0d y=%0d X=%0d Y=%0d strb=%b", x, y, X, Y, strb);
                end
            end
            if (finish === 1'b1) fin_c = c;
        end
        hold = 1'b0;
        n_checks++;
        if (fin_c !== 3265) begin
            n_fail++;
            $display("FAIL hold_finish_cycle: got %0d, need 3265", fin_c);
        end
        step; #1;
    endtask

    task automatic test_rst_mid;
        int fin_c = -1;
        int ov_cnt = 0;
        for (int c = 0; c <= 101; c++) begin
            step; start = (c == 0); rst = (c == 101); #1;
        end
        n_checks++;
        if (X !== 5'd10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_point: X=%0d busy=%b, need 10 and 1", X, busy);
        end
        step; rst = 1'b0; #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h, need 0", all_out);
        end
        for (int i = 0; i < 3; i++) begin
            step; #1;
            n_checks++;
            if (finish !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_idle: finish=%b busy=%b", finish, busy);
            end
        end
        for (int c = 0; c <= 3400 && fin_c < 0; c++) begin
            step; start = (c == 0); #1;
            if (out_valid === 1'b1) ov_cnt++;
            if (finish === 1'b1) fin_c = c;
        end
        n_checks++;
        if (fin_c !== 3260 || ov_cnt !== 361) begin
            n_fail++;
            $display("FAIL rerun_after_rst: finish_cyc=%0d ov=%0d, need 3260 and 361", fin_c, ov_cnt);
        end
        step; #1;
    endtask

    task automatic test_restart_ignored;
        int fin_c = -1;
        int fin_cnt = 0;
        int ov_cnt = 0;
        for (int c = 0; c <= 3265; c++) begin
            step; start = (c == 0 || c == 5 || c == 500 || c == 3260); #1;
            if (out_valid === 1'b1) ov_cnt++;
            if (finish === 1'b1) begin
                fin_cnt++;
                fin_c = c;
            end
            if (c >= 3261) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_in_done cyc %0d: busy=%b, need 0", c, busy);
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (ov_cnt !== 361 || fin_cnt !== 1 || fin_c !== 3260) begin
            n_fail++;
            $display("FAIL restart_ignored: ov=%0d fins=%0d fin_cyc=%0d, need 361 1 3260", ov_cnt,
                     fin_cnt, fin_c);
        end
`ifdef CONV_SEQ_PERF_EN
        n_checks++;
        if (cyc_cnt !== 32'd3261 || stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_counts: cyc=%0d stall=%0d, need 3261 and 0", cyc_cnt, stall_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        test_reset;
        test_free_run;
        test_load_hold;
        test_hold;
        test_rst_mid;
        test_restart_ignored;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
